seq_serializer: RTL



---
 rtl/seq_serializer_pkg.sv | 19 +
 rtl/seq_serializer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer front end: state encoding and counter sizing.
// The detector bench reuses the same encodings and widths.
package seq_serializer_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_GAP   = 2'd2
  } ser_state_e;

  localparam int GCNT_W = 4;
  localparam int WCNT_W = 16;

  // Bit-counter width; never below one bit so the counter register always exists.
  function automatic int bcnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word per handshake, one bit per clock,
// with GAP forced-zero cycles between words so the downstream detector sees framed data.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic [WCNT_W-1:0] words_sent
);

  localparam int                BW        = bcnt_width(WIDTH);
  localparam logic [BW-1:0]     BCNT_LOAD = BW'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GAP > 0 ? GAP - 1 : 0);

  ser_state_e        state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [BW-1:0]     bcnt_q;
  logic [GCNT_W-1:0] gcnt_q;
  logic              sout_q;
  logic              sout_valid_q;
  logic [WCNT_W-1:0] words_sent_q;

  logic              accept;
  logic              din_first;
  logic [WIDTH-1:0]  din_rest;
  logic              head_bit;
  logic [WIDTH-1:0]  shreg_adv;

  // The shift register holds only the bits not yet on the line; the first bit
  // goes straight from din to sout at the accept edge.
  if (MSB_FIRST) begin : g_msb
    assign din_first = din[WIDTH-1];
    assign din_rest  = {din[WIDTH-2:0], 1'b0};
    assign head_bit  = shreg_q[WIDTH-1];
    assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
  end else begin : g_lsb
    assign din_first = din[0];
    assign din_rest  = {1'b0, din[WIDTH-1:1]};
    assign head_bit  = shreg_q[0];
    assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    din_ready = 1'b0;
    unique case (state_q)
      SER_IDLE:  din_ready = 1'b1;
      SER_SHIFT: din_ready = (bcnt_q == '0) && (GAP == 0);
      SER_GAP:   din_ready = (gcnt_q == '0);
      default:   din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid & din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SER_IDLE;
      shreg_q      <= '0;
      bcnt_q       <= '0;
      gcnt_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      words_sent_q <= '0;
    end else begin
      if ((state_q == SER_SHIFT) && (bcnt_q == '0)) begin
        words_sent_q <= words_sent_q + 1'b1;
      end
      if (accept) begin
        state_q      <= SER_SHIFT;
        shreg_q      <= din_rest;
        bcnt_q       <= BCNT_LOAD;
        sout_q       <= din_first;
        sout_valid_q <= 1'b1;
      end else begin
        unique case (state_q)
          SER_SHIFT: begin
            if (bcnt_q != '0) begin
              sout_q  <= head_bit;
              shreg_q <= shreg_adv;
              bcnt_q  <= bcnt_q - 1'b1;
            end else begin
              sout_q       <= 1'b0;
              sout_valid_q <= 1'b0;
              if (GAP == 0) begin
                state_q <= SER_IDLE;
              end else begin
                state_q <= SER_GAP;
                gcnt_q  <= GCNT_LOAD;
              end
            end
          end
          SER_GAP: begin
            if (gcnt_q != '0) begin
              gcnt_q <= gcnt_q - 1'b1;
            end else begin
              state_q <= SER_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = (state_q != SER_IDLE);
  assign words_sent = words_sent_q;

endmodule
